// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_W data bits LSB first, 1 stop bit.
// Byte accepted on din_vld && rdy; dout and rdy are both registered.
module uart_tx #(
  parameter int CNT_MAX = 2604,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              rdy,
  output logic              dout
);

  localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_END = CW'(CNT_MAX - 1);
  localparam logic [3:0] BIT_LAST = 4'(DATA_W);
  localparam logic [3:0] BIT_STOP = 4'(DATA_W + 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt0;
  logic [3:0]        cnt1;
  logic [DATA_W-1:0] shreg;
  logic              bit_end;

  assign bit_end = (state == SEND) && (cnt0 == CNT_END);

  // Baud counter: runs only while sending, wraps at the end of each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
    end else if (state == SEND) begin
      if (bit_end) cnt0 <= '0;
      else         cnt0 <= cnt0 + 1'b1;
    end
  end

  // Bit counter: 0 = start, 1..DATA_W = data, DATA_W+1 = stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
    end else if (bit_end) begin
      if (cnt1 == BIT_STOP) cnt1 <= '0;
      else                  cnt1 <= cnt1 + 1'b1;
    end
  end

  // Frame FSM: loads the byte, drives the line level for each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy   <= 1'b1;
      dout  <= 1'b1;
      shreg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (din_vld) begin
            shreg <= din;
            state <= SEND;
            rdy   <= 1'b0;
            dout  <= 1'b0;
          end
        end
        SEND: begin
          if (bit_end) begin
            if (cnt1 == BIT_STOP) begin
              state <= IDLE;
              rdy   <= 1'b1;
              dout  <= 1'b1;
            end else if (cnt1 == BIT_LAST) begin
              dout <= 1'b1;
            end else begin
              dout  <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: fast-baud instance for frame checks,
// default-baud instance for the full-rate loopback.
module tb_uart_tx;

  localparam int CM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_vld = 1'b0;
  logic       rdy;
  logic       dout;
  logic [7:0] d_din = 8'h00;
  logic       d_vld = 1'b0;
  logic       d_rdy;
  logic       d_dout;

  int         checks = 0;
  int         errors = 0;
  int         acc = 0;
  longint     cyc = 0;
  logic [7:0] q[$];

  uart_tx #(.CNT_MAX(CM), .DATA_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_vld (din_vld),
    .rdy     (rdy),
    .dout    (dout)
  );

  uart_tx dut_def (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (d_din),
    .din_vld (d_vld),
    .rdy     (d_rdy),
    .dout    (d_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (rst_n && din_vld && rdy) acc <= acc + 1;

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Present a byte, wait for rdy, push it at the accept edge.
  task automatic send(input logic [7:0] b, output bit ok);
    @(negedge clk);
    din = b;
    din_vld = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      q.push_back(b);
      #1 din_vld = 1'b0;
    end else begin
      din_vld = 1'b0;
    end
  endtask

  // Collect one frame from the fast instance, one sample per cycle.
  task automatic rx_fast(output logic [9:0] bits, output bit stable,
                         output int low, output logic rdy_end,
                         output logic dout_end, output bit seen,
                         output longint t0);
    logic s;
    bits = '0;
    stable = 1'b1;
    low = 0;
    rdy_end = 1'bx;
    dout_end = 1'bx;
    seen = 1'b0;
    t0 = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (dout === 1'b0) seen = 1'b1;
    end
    if (!seen) return;
    t0 = cyc;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CM; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        s = dout;
        if (c == 0) bits[b] = s;
        else if (s !== bits[b]) stable = 1'b0;
        if (rdy === 1'b0) low++;
      end
    end
    @(negedge clk);
    rdy_end = rdy;
    dout_end = dout;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din = 8'hFF;
    din_vld = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (dout !== 1'b1) begin
        errors++;
        $display("FAIL reset_dout: got %b want 1", dout);
      end
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("FAIL reset_rdy: got %b want 1", rdy);
      end
    end
    din_vld = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rdy !== 1'b1 || dout !== 1'b1 || d_rdy !== 1'b1 ||
          d_dout !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle: rdy=%b dout=%b d_rdy=%b d_dout=%b want all 1",
                 rdy, dout, d_rdy, d_dout);
      end
    end
    checks++;
    if (acc !== 0) begin
      errors++;
      $display("FAIL reset_no_accept: got %0d accepts want 0", acc);
    end
  endtask

  task automatic test_single();
    bit ok, st, sn;
    int low;
    logic re, de;
    logic [9:0] bits;
    logic [7:0] exp;
    longint t0;
    send(8'h55, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_accept: got no handshake want accept");
    end
    rx_fast(bits, st, low, re, de, sn, t0);
    checks++;
    if (!sn) begin
      errors++;
      $display("FAIL single_start: got no start bit want start");
      return;
    end
    exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
    checks++;
    if (bits !== frame(exp)) begin
      errors++;
      $display("FAIL single_bits: got %b want %b", bits, frame(exp));
    end
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL single_width: got unstable level want %0d-cycle bits", CM);
    end
    checks++;
    if (low !== 40 || re !== 1'b1 || de !== 1'b1) begin
      errors++;
      $display("FAIL single_rdy: got low=%0d rdy_end=%b dout_end=%b want 40 1 1",
               low, re, de);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, st1, st2, sn1, sn2;
    int low1, low2, a0;
    logic re1, re2, de1, de2;
    logic [9:0] b1, b2;
    logic [7:0] e1, e2;
    longint t1, t2;
    a0 = acc;
    ok1 = 1'b0;
    ok2 = 1'b0;
    fork
      begin
        @(negedge clk);
        din = 8'hA3;
        din_vld = 1'b1;
        if (rdy === 1'b1) begin
          ok1 = 1'b1;
          @(posedge clk);
          q.push_back(8'hA3);
          #1 din = 8'h0F;
          for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
              ok2 = 1'b1;
              break;
            end
          end
          if (ok2) begin
            @(posedge clk);
            q.push_back(8'h0F);
            #1;
          end
        end
        din_vld = 1'b0;
      end
      begin
        rx_fast(b1, st1, low1, re1, de1, sn1, t1);
        rx_fast(b2, st2, low2, re2, de2, sn2, t2);
      end
    join
    checks++;
    if (!ok1 || !ok2 || !sn1 || !sn2) begin
      errors++;
      $display("FAIL b2b_handshake: got ok=%b%b start=%b%b want 1111",
               ok1, ok2, sn1, sn2);
      return;
    end
    e1 = (q.size() > 0) ? q.pop_front() : 8'hxx;
    e2 = (q.size() > 0) ? q.pop_front() : 8'hxx;
    checks++;
    if (b1 !== frame(e1) || !st1) begin
      errors++;
      $display("FAIL b2b_frame1: got %b stable=%b want %b", b1, st1, frame(e1));
    end
    checks++;
    if (b2 !== frame(e2) || !st2) begin
      errors++;
      $display("FAIL b2b_frame2: got %b stable=%b want %b", b2, st2, frame(e2));
    end
    checks++;
    if (t2 - t1 !== 41) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want 41", t2 - t1);
    end
    checks++;
    if (acc - a0 !== 2) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d want 2", acc - a0);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok, st, sn;
    int low, a0;
    logic re, de;
    logic [9:0] bits;
    logic [7:0] exp;
    longint t0;
    a0 = acc;
    fork
      begin
        send(8'hC4, ok);
        repeat (10) @(negedge clk);
        din = 8'h00;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
      end
      rx_fast(bits, st, low, re, de, sn, t0);
    join
    checks++;
    if (!ok || !sn) begin
      errors++;
      $display("FAIL busy_start: got ok=%b start=%b want 1 1", ok, sn);
      return;
    end
    exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
    checks++;
    if (bits !== frame(exp) || !st) begin
      errors++;
      $display("FAIL busy_frame: got %b stable=%b want %b", bits, st, frame(exp));
    end
    checks++;
    if (low !== 40 || re !== 1'b1) begin
      errors++;
      $display("FAIL busy_rdy: got low=%0d rdy_end=%b want 40 1", low, re);
    end
    checks++;
    if (acc - a0 !== 1 || q.size() !== 0) begin
      errors++;
      $display("FAIL busy_accepts: got %0d queued=%0d want 1 0",
               acc - a0, q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, st, sn;
    int low;
    logic re, de;
    logic [9:0] bits;
    logic [7:0] exp;
    longint t0;
    send(8'h00, ok);
    repeat (17) @(negedge clk);
    checks++;
    if (!ok || dout !== 1'b0 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_inframe: got ok=%b dout=%b rdy=%b want 1 0 0",
               ok, dout, rdy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 1'b1 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_async_reset: got dout=%b rdy=%b want 1 1", dout, rdy);
    end
    if (q.size() > 0) void'(q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h81, ok);
    rx_fast(bits, st, low, re, de, sn, t0);
    checks++;
    if (!ok || !sn) begin
      errors++;
      $display("FAIL mid_resend: got ok=%b start=%b want 1 1", ok, sn);
      return;
    end
    exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
    checks++;
    if (bits !== frame(exp) || !st || low !== 40 || re !== 1'b1) begin
      errors++;
      $display("FAIL mid_clean_frame: got %b stable=%b low=%0d want %b 1 40",
               bits, st, low, frame(exp));
    end
  endtask

  task automatic test_default();
    bit seen;
    int rise, low, idx;
    logic stopb, rend;
    logic [7:0] got, exp;
    seen = 1'b0;
    rise = -1;
    low = 0;
    stopb = 1'bx;
    rend = 1'bx;
    got = 'x;
    @(negedge clk);
    d_din = 8'h3C;
    d_vld = 1'b1;
    @(posedge clk);
    q.push_back(8'h3C);
    #1 d_vld = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (d_dout === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL def_start: got no start bit want start");
      return;
    end
    for (int n = 0; n <= 26040; n++) begin
      if (n > 0) @(negedge clk);
      if (n < 26040 && d_rdy === 1'b0) low++;
      if (rise < 0 && d_dout === 1'b1) rise = n;
      if (n >= 1302 && (n - 1302) % 2604 == 0) begin
        idx = (n - 1302) / 2604;
        if (idx >= 1 && idx <= 8) got[idx-1] = d_dout;
        if (idx == 9) stopb = d_dout;
      end
      if (n == 26040) rend = d_rdy;
    end
    exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
    checks++;
    if (got !== exp || stopb !== 1'b1) begin
      errors++;
      $display("FAIL def_loopback: got %h stop=%b want %h 1", got, stopb, exp);
    end
    checks++;
    if (rise !== 7812) begin
      errors++;
      $display("FAIL def_bit_width: got first rise at %0d want 7812", rise);
    end
    checks++;
    if (low !== 26040 || rend !== 1'b1) begin
      errors++;
      $display("FAIL def_frame_len: got low=%0d rdy_end=%b want 26040 1",
               low, rend);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_default();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
